// File: rtl/bubblesort_pkg.sv
// rtl/bubblesort_pkg.sv - shared state encoding and default geometry for the bubblesort block and its result streamer
package bubblesort_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      FETCH = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/sort_order_checker.sv
// rtl/sort_order_checker.sv - flags descending pairs in the accepted element stream
module sort_order_checker #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic              first,
   input  logic [DATA_W-1:0] data,
   output logic              sorted_ok,
   output logic [ADDR_W-1:0] err_count
);

   logic [DATA_W-1:0] prev_q, prev_d;
   logic              ok_q, ok_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      prev_d = prev_q;
      ok_d   = ok_q;
      cnt_d  = cnt_q;
      if (clear) begin
         ok_d  = 1'b1;
         cnt_d = '0;
      end else if (accept) begin
         prev_d = data;
         // Equal neighbours count as in order; the counter saturates at all-ones.
         if (!first && (data < prev_q)) begin
            ok_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         ok_q   <= 1'b1;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         ok_q   <= ok_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sorted_ok = ok_q;
   assign err_count = cnt_q;

endmodule

// File: rtl/sort_result_streamer.sv
// rtl/sort_result_streamer.sv - streams the sorter memory out once per complete edge
// Order checking is built only when SORT_CHECK_EN is defined.
module sort_result_streamer
   import bubblesort_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              complete,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              done,
   output logic              sorted_ok,
   output logic [ADDR_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              complete_prev_q, complete_prev_d;
   logic              armed_q, armed_d;
   logic              start;

   // A pass needs complete to have been seen low since reset, so a level
   // that is already high when reset releases never counts as an edge.
   assign start           = complete && !complete_prev_q && armed_q;
   assign complete_prev_d = complete;
   assign armed_d         = armed_q || !complete;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               idx_d   = '0;
            end
         end
         READ: state_d = FETCH;
         FETCH: begin
            out_data_d = mem_rdata;
            out_last_d = (idx_q == LAST_IDX);
            state_d    = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_last_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = READ;
               end
            end
         end
         DONE: begin
            if (!complete) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         out_data_q      <= '0;
         out_last_q      <= 1'b0;
         complete_prev_q <= 1'b0;
         armed_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         out_data_q      <= out_data_d;
         out_last_q      <= out_last_d;
         complete_prev_q <= complete_prev_d;
         armed_q         <= armed_d;
      end
   end

   assign mem_addr  = idx_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_valid = (state_q == SEND);
   assign done      = (state_q == DONE);

`ifdef SORT_CHECK_EN
   logic chk_clear;
   logic chk_accept;

   assign chk_clear  = (state_q == IDLE) && start;
   assign chk_accept = (state_q == SEND) && out_ready;

   sort_order_checker #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_order_checker (
      .clk       (clk),
      .rst       (rst),
      .clear     (chk_clear),
      .accept    (chk_accept),
      .first     (idx_q == '0),
      .data      (out_data_q),
      .sorted_ok (sorted_ok),
      .err_count (err_count)
   );
`else
   assign sorted_ok = 1'b1;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// tb/tb_sort_result_streamer.sv - directed self-checking bench for sort_result_streamer
module tb_sort_result_streamer;

   logic       clk = 1'b0;
   logic       rst;
   logic       complete;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       done;
   logic       sorted_ok;
   logic [3:0] err_count;

   logic [7:0] mem [16];
   int checks  = 0;
   int errors  = 0;
   int overlap = 0;
   int lat;
   int seen;
   logic       exp_ok;
   logic [3:0] exp_err;

   sort_result_streamer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .complete  (complete),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .done      (done),
      .sorted_ok (sorted_ok),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr];

   always @(negedge clk) if (done && out_valid) overlap++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_last"}, 32'(out_last), 0);
      chk({tag, "_ok"}, 32'(sorted_ok), 1);
      chk({tag, "_err"}, 32'(err_count), 0);
   endtask

   task automatic start_pass(output int latency);
      complete = 1'b1;
      latency  = 0;
      while (out_valid !== 1'b1 && latency < 20) begin
         step();
         latency++;
      end
   endtask

   task automatic stream(input int n, input int stall_at);
      int waits;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) out_ready = 1'b0;
         waits = 0;
         while (out_valid !== 1'b1 && waits < 20) begin
            step();
            waits++;
         end
         chk("valid_seen", 32'(out_valid), 1);
         if (out_valid !== 1'b1) return;
         if (i > 0 && i != stall_at) chk("elem_gap", waits, 2);
         chk("elem_data", 32'(out_data), 32'(mem[i]));
         chk("elem_last", 32'(out_last), 32'(i == 15));
         chk("elem_addr", 32'(mem_addr), i);
         if (i == stall_at) begin
            for (int k = 0; k < 5; k++) begin
               step();
               chk("stall_data", 32'(out_data), 32'(mem[i]));
               chk("stall_valid", 32'(out_valid), 1);
            end
            out_ready = 1'b1;
         end
         step();
      end
   endtask

   task automatic finish_pass(input logic ok, input logic [3:0] err);
      chk("done_set", 32'(done), 1);
      chk("done_no_valid", 32'(out_valid), 0);
      chk("pass_ok", 32'(sorted_ok), 32'(ok));
      chk("pass_err", 32'(err_count), 32'(err));
      step();
      chk("done_held", 32'(done), 1);
      complete = 1'b0;
      step();
      chk("done_clear", 32'(done), 0);
   endtask

   initial begin
      rst       = 1'b1;
      complete  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      step();
      step();
      chk_reset_values("reset");

      // complete already high out of reset must not start a pass
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (out_valid) seen++;
      end
      chk("no_start_high_from_reset", seen, 0);

      // ascending pass with a 5-cycle stall on element 07
      complete = 1'b0;
      step();
      start_pass(lat);
      chk("first_latency", lat, 3);
      stream(16, 7);
      finish_pass(1'b1, 4'd0);

      // two descending pairs: 3>1 and 2>0
      mem[0] = 8'h03;
      mem[1] = 8'h01;
      mem[2] = 8'h02;
      mem[3] = 8'h00;
`ifdef SORT_CHECK_EN
      exp_ok  = 1'b0;
      exp_err = 4'd2;
`else
      exp_ok  = 1'b1;
      exp_err = 4'd0;
`endif
      step();
      start_pass(lat);
      chk("second_latency", lat, 3);
      stream(16, -1);
      finish_pass(exp_ok, exp_err);

      // reset after four accepted elements aborts the pass
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
      step();
      start_pass(lat);
      stream(4, -1);
      rst = 1'b1;
      step();
      chk_reset_values("midpass_reset");
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (out_valid) seen++;
      end
      chk("no_emit_after_reset", seen, 0);
      complete = 1'b0;
      step();
      start_pass(lat);
      chk("restart_latency", lat, 3);
      stream(16, -1);
      finish_pass(1'b1, 4'd0);

      // all-equal contents are in order; previous pass counters are cleared
      for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
      step();
      start_pass(lat);
      chk("equal_ok_at_start", 32'(sorted_ok), 1);
      chk("equal_err_at_start", 32'(err_count), 0);
      stream(16, -1);
      finish_pass(1'b1, 4'd0);

      chk("done_valid_overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
